// File: rtl/ffram_pkg.sv
// Shared types and helpers for the flip-flop RAM Wishbone bridge.
package ffram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    ACK
  } ffram_bridge_state_t;

  // Widest byte-select vector the mask helper supports (128-bit words).
  localparam int unsigned MAX_SEL_W = 16;

  // Expand each byte-select bit into a full byte of mask bits.
  function automatic logic [8*MAX_SEL_W-1:0] sel_to_mask(input logic [MAX_SEL_W-1:0] sel);
    logic [8*MAX_SEL_W-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_SEL_W; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ffram_wb_bridge.sv
// Wishbone-classic slave driving a flip-flop RAM native port.
// Partial byte writes are done as read-modify-write since the RAM has no
// byte-write; read data is registered before being returned on the bus.
module ffram_wb_bridge
  import ffram_pkg::*;
#(
  parameter int unsigned WORD_NUM = 256,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned AD_WIDTH = $clog2(WORD_NUM),
  parameter int unsigned SEL_W    = WORD_W / 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [SEL_W-1:0]    wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [WORD_W-1:0]   wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [WORD_W-1:0]   wbs_dat_o,
  output logic [WORD_W-1:0]   ram_d_in,
  output logic [WORD_W-1:0]   ram_bit_en,
  output logic [AD_WIDTH-1:0] ram_addr,
  output logic                ram_wb_en,
  output logic                ram_r_en,
  input  logic [WORD_W-1:0]   ram_d_out
);

  ffram_bridge_state_t state_q, state_d;
  logic [AD_WIDTH-1:0] adr_q, adr_d;
  logic [WORD_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [WORD_W-1:0]   old_q, old_d;
  logic [WORD_W-1:0]   rdat_q, rdat_d;

  logic [8*MAX_SEL_W-1:0] mask_wide;
  logic [WORD_W-1:0]      mask;
  logic                   req;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign mask_wide = sel_to_mask(MAX_SEL_W'(sel_q));
  assign mask      = mask_wide[WORD_W-1:0];

  if (WORD_W < 8 * MAX_SEL_W) begin : g_mask_pad
    logic unused_mask_hi;
    assign unused_mask_hi = ^mask_wide[8*MAX_SEL_W-1:WORD_W];
  end

  // Only the word-index bits of the byte address matter; the rest alias.
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:AD_WIDTH+2], wbs_adr_i[1:0]};

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      old_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      old_q   <= old_d;
      rdat_q  <= rdat_d;
    end
  end

  // Next-state and register-load decode; once past IDLE the RAM access runs
  // to completion regardless of cyc/stb so RAM operations stay atomic.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    old_d   = old_q;
    rdat_d  = rdat_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          adr_d = wbs_adr_i[AD_WIDTH+1:2];
          dat_d = wbs_dat_i;
          sel_d = wbs_sel_i;
          if (!wbs_we_i)              state_d = RD;
          else if (&wbs_sel_i)        state_d = WR;
          else if (wbs_sel_i == '0)   state_d = ACK;
          else                        state_d = RMW_RD;
        end
      end
      RD: begin
        rdat_d  = ram_d_out;
        state_d = ACK;
      end
      RMW_RD: begin
        old_d   = ram_d_out;
        state_d = WR;
      end
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port and bus outputs decoded purely from registered state, so an
  // asynchronous reset removes the RAM enable immediately.
  always_comb begin
    ram_wb_en  = 1'b0;
    ram_r_en   = 1'b0;
    ram_bit_en = '0;
    ram_d_in   = '0;
    ram_addr   = adr_q;
    unique case (state_q)
      RD, RMW_RD: begin
        ram_wb_en  = 1'b1;
        ram_r_en   = 1'b1;
        ram_bit_en = '1;
      end
      WR: begin
        ram_wb_en  = 1'b1;
        ram_bit_en = '1;
        // With a full mask this reduces to dat_q, covering full writes too.
        ram_d_in   = (old_q & ~mask) | (dat_q & mask);
      end
      default: ;
    endcase
    wbs_ack_o = (state_q == ACK) & req;
    wbs_dat_o = rdat_q;
  end

endmodule
